// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI4 read responder.
// Build option: AXI_RD_WAIT_STATE_EN adds the WAIT state to the FSM encoding.
package axi_rd_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef AXI_RD_WAIT_STATE_EN
        S_WAIT  = 2'd1,
`endif
        S_BURST = 2'd2
    } rd_state_e;

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Combinational beat-address stepping (FIXED/INCR/WRAP) and burst legality for the read responder.
// Build option AXI_RD_WAIT_STATE_EN does not affect this block.
module axi_rd_addr_gen
    import axi_rd_pkg::*;
(
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_len,
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_burst,
    output logic [31:0] o_next_addr,
    output logic        o_legal
);

    burst_e      w_burst;
    logic [31:0] w_bytes;
    logic [31:0] w_win_mask;
    logic        w_wrap_len_ok;
    logic        w_aligned;

    assign w_burst    = burst_e'(i_burst);
    assign w_bytes    = 32'd1 << i_size;
    // WRAP window is (len+1) beats wide and aligned to its own size.
    assign w_win_mask = ((32'(i_len) + 32'd1) << i_size) - 32'd1;

    always_comb begin
        o_next_addr = i_addr;
        case (w_burst)
            BURST_INCR: o_next_addr = i_addr + w_bytes;
            BURST_WRAP: o_next_addr = (i_addr & ~w_win_mask) | ((i_addr + w_bytes) & w_win_mask);
            default:    o_next_addr = i_addr;
        endcase
    end

    assign w_wrap_len_ok = (i_len == 4'd1) || (i_len == 4'd3) || (i_len == 4'd7) || (i_len == 4'd15);
    assign w_aligned     = ((i_addr & (w_bytes - 32'd1)) == 32'd0);

    assign o_legal = (w_burst != BURST_RSVD) && (i_size <= 3'd2)
                   && !((w_burst == BURST_WRAP) && !(w_wrap_len_ok && w_aligned));

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-only responder serving R beats from an internal word memory with a backdoor preload port.
// Build option: define AXI_RD_WAIT_STATE_EN to delay the first beat by WAIT_CYCLES wait states.
module axi_rd_responder
    import axi_rd_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                      G_clk,
    input  logic                      G_reset,
    input  logic [31:0]               ARADDR,
    input  logic [3:0]                ARLEN,
    input  logic [2:0]                ARSIZE,
    input  logic [1:0]                ARBURST,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_W-1:0]         RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY,
    input  logic                      mem_we,
    input  logic [$clog2(DEPTH)-1:0]  mem_waddr,
    input  logic [DATA_W-1:0]         mem_wdata
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("axi_rd_responder: DEPTH must be a power of two >= 2");
    end
    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_wait
        $error("axi_rd_responder: WAIT_CYCLES must be 0..15");
    end

    rd_state_e         r_state;
    logic              r_arready;
    logic              r_rvalid;
    logic              r_rlast;
    logic [1:0]        r_rresp;
    logic [DATA_W-1:0] r_rdata;
    logic [31:0]       r_addr;
    logic [3:0]        r_len;
    logic [3:0]        r_beat;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_burst_err;
`ifdef AXI_RD_WAIT_STATE_EN
    logic [3:0]        r_wait_cnt;
`endif
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [31:0]       w_gen_addr;
    logic [3:0]        w_gen_len;
    logic [2:0]        w_gen_size;
    logic [1:0]        w_gen_burst;
    logic [31:0]       w_next_addr;
    logic              w_legal;
    logic [31:0]       w_load_addr;
    logic              w_load_err;
    logic [31:0]       w_offset;
    logic              w_load_ok;
    logic [DATA_W-1:0] w_load_data;
    logic [1:0]        w_load_resp;

    // NOTE: the storage array has no reset; only control and output registers are cleared.
    always_ff @(posedge G_clk) begin
        if (mem_we) begin
            r_mem[mem_waddr] <= mem_wdata;
        end
    end

    // In IDLE the generator checks the incoming request; afterwards it steps the latched burst.
    assign w_gen_addr  = (r_state == S_IDLE) ? ARADDR  : r_addr;
    assign w_gen_len   = (r_state == S_IDLE) ? ARLEN   : r_len;
    assign w_gen_size  = (r_state == S_IDLE) ? ARSIZE  : r_size;
    assign w_gen_burst = (r_state == S_IDLE) ? ARBURST : r_burst;

    axi_rd_addr_gen u_addr_gen (
        .i_addr      (w_gen_addr),
        .i_len       (w_gen_len),
        .i_size      (w_gen_size),
        .i_burst     (w_gen_burst),
        .o_next_addr (w_next_addr),
        .o_legal     (w_legal)
    );

    always_comb begin
        w_load_addr = r_addr;
        w_load_err  = r_burst_err;
        case (r_state)
            S_IDLE: begin
                w_load_addr = ARADDR;
                w_load_err  = !w_legal;
            end
            S_BURST: w_load_addr = w_next_addr;
            default: w_load_addr = r_addr;
        endcase
    end

    assign w_offset    = w_load_addr - BASE_ADDR;
    assign w_load_ok   = !w_load_err && (w_load_addr >= BASE_ADDR) && ({1'b0, w_offset} < MEM_BYTES);
    assign w_load_data = w_load_ok ? r_mem[w_offset[AW+1:2]] : '0;
    assign w_load_resp = w_load_ok ? RESP_OKAY : RESP_SLVERR;

    // NOTE: all state and output registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge G_clk or posedge G_reset) begin
        if (G_reset) begin
            r_state     <= S_IDLE;
            r_arready   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_rresp     <= RESP_OKAY;
            r_rdata     <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_burst_err <= 1'b0;
`ifdef AXI_RD_WAIT_STATE_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ARVALID && r_arready) begin
                        r_arready   <= 1'b0;
                        r_addr      <= ARADDR;
                        r_len       <= ARLEN;
                        r_size      <= ARSIZE;
                        r_burst     <= ARBURST;
                        r_burst_err <= !w_legal;
                        r_beat      <= '0;
`ifdef AXI_RD_WAIT_STATE_EN
                        if (WAIT_CYCLES == 0) begin
                            r_rdata  <= w_load_data;
                            r_rresp  <= w_load_resp;
                            r_rlast  <= (ARLEN == 4'd0);
                            r_rvalid <= 1'b1;
                            r_state  <= S_BURST;
                        end else begin
                            r_wait_cnt <= 4'(WAIT_CYCLES - 1);
                            r_state    <= S_WAIT;
                        end
`else
                        r_rdata  <= w_load_data;
                        r_rresp  <= w_load_resp;
                        r_rlast  <= (ARLEN == 4'd0);
                        r_rvalid <= 1'b1;
                        r_state  <= S_BURST;
`endif
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
`ifdef AXI_RD_WAIT_STATE_EN
                S_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_rdata  <= w_load_data;
                        r_rresp  <= w_load_resp;
                        r_rlast  <= (r_len == 4'd0);
                        r_rvalid <= 1'b1;
                        r_state  <= S_BURST;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
`endif
                S_BURST: begin
                    if (r_rvalid && RREADY) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_addr  <= w_next_addr;
                            r_beat  <= r_beat + 4'd1;
                            r_rdata <= w_load_data;
                            r_rresp <= w_load_resp;
                            r_rlast <= ((r_beat + 4'd1) == r_len);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
    assign RLAST   = r_rlast;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Self-checking bench for axi_rd_responder: directed AR requests, scoreboarded R beats.
// Honours AXI_RD_WAIT_STATE_EN for the expected first-beat latency.
`timescale 1ns/1ps
module tb_axi_rd_responder;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 256;
    localparam int          WAITC = 3;
`ifdef AXI_RD_WAIT_STATE_EN
    localparam int          EXP_K = WAITC;
`else
    localparam int          EXP_K = 0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        G_clk = 1'b0;
    logic        G_reset;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;

    logic [31:0] tb_mem [DEPTH];
    beat_t       exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 G_clk = ~G_clk;

    axi_rd_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .G_clk     (G_clk),
        .G_reset   (G_reset),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARSIZE    (ARSIZE),
        .ARBURST   (ARBURST),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RLAST     (RLAST),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: expands one request into its expected beats.
    task automatic push_expected(input logic [31:0] a0, input logic [3:0] len,
                                 input logic [2:0] size, input logic [1:0] burst);
        longint bytes, win, wbase, a, start;
        bit     err, ok;
        beat_t  b;
        start = longint'(a0);
        bytes = longint'(1) << size;
        win   = (longint'(len) + 1) * bytes;
        err   = (burst == 2'b11) || (size > 3'd2)
             || (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15))
             || (burst == 2'b10 && (start % bytes) != 0);
        wbase = start - (start % win);
        for (int i = 0; i <= int'(len); i++) begin
            case (burst)
                2'b01:   a = (start + i * bytes) & 64'hFFFF_FFFF;
                2'b10:   a = wbase + ((start - wbase + i * bytes) % win);
                default: a = start;
            endcase
            ok     = !err && (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
            b.data = ok ? tb_mem[int'((a - longint'(BASE)) / 4)] : 32'h0;
            b.resp = ok ? 2'b00 : 2'b10;
            b.last = (i == int'(len));
            exp_q.push_back(b);
        end
    endtask

    // Scoreboard: compare each beat the master accepts.
    always @(negedge G_clk) begin
        beat_t e;
        if (RVALID && RREADY && !G_reset) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("rdata", RDATA, e.data);
                check("rresp", 32'(RRESP), 32'(e.resp));
                check("rlast", 32'(RLAST), 32'(e.last));
            end
        end
    end

    task automatic write_mem(input int idx, input logic [31:0] d);
        mem_we    = 1'b1;
        mem_waddr = 8'(idx);
        mem_wdata = d;
        @(posedge G_clk); #1;
        mem_we    = 1'b0;
        tb_mem[idx] = d;
    endtask

    task automatic issue_ar(input logic [31:0] a, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n;
        int k;
        push_expected(a, len, size, burst);
        ARADDR  = a;
        ARLEN   = len;
        ARSIZE  = size;
        ARBURST = burst;
        ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin
            @(posedge G_clk); #1;
            n++;
        end
        check("arready_before_accept", 32'(ARREADY), 32'd1);
        @(posedge G_clk); #1;
        ARVALID = 1'b0;
        check("arready_after_accept", 32'(ARREADY), 32'd0);
        k = 0;
        while (!RVALID && k < 40) begin
            @(posedge G_clk); #1;
            k++;
        end
        check("first_beat_latency", 32'(k), 32'(EXP_K));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((RVALID || exp_q.size() != 0) && n < 200) begin
            @(posedge G_clk); #1;
            n++;
        end
        check("burst_done_in_budget", 32'(n < 200), 32'd1);
        check("arready_turnaround", 32'(ARREADY), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        G_reset   = 1'b1;
        ARADDR    = '0;
        ARLEN     = '0;
        ARSIZE    = '0;
        ARBURST   = '0;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;

        repeat (2) @(posedge G_clk);
        #1;
        check("reset_arready", 32'(ARREADY), 32'd0);
        check("reset_rvalid",  32'(RVALID),  32'd0);
        check("reset_rlast",   32'(RLAST),   32'd0);
        check("reset_rresp",   32'(RRESP),   32'd0);
        check("reset_rdata",   RDATA,        32'd0);
        G_reset = 1'b0;
        check("arready_before_first_edge", 32'(ARREADY), 32'd0);
        @(posedge G_clk); #1;
        check("arready_after_reset", 32'(ARREADY), 32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            if (i >= 4 && i <= 7) write_mem(i, 32'hA0 + 32'(i - 4));
            else                  write_mem(i, 32'hC0DE_0000 | 32'(i));
        end

        RREADY = 1'b1;
        issue_ar(32'h10, 4'd3, 3'd2, 2'b01);   // INCR A0..A3
        wait_done();
        issue_ar(32'h08, 4'd3, 3'd2, 2'b10);   // WRAP words 2,3,0,1
        wait_done();
        issue_ar(32'h30, 4'd2, 3'd2, 2'b00);   // FIXED, same word x3
        wait_done();

        issue_ar(32'h20, 4'd3, 3'd2, 2'b01);
        @(posedge G_clk); #1;
        RREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_rvalid", 32'(RVALID), 32'd1);
            check("bp_rdata",  RDATA, exp_q[0].data);
            check("bp_rlast",  32'(RLAST), 32'(exp_q[0].last));
            @(posedge G_clk); #1;
        end
        RREADY = 1'b1;
        wait_done();

        issue_ar(32'h40, 4'd1, 3'd2, 2'b11);   // reserved burst
        wait_done();
        issue_ar(32'h3F8, 4'd3, 3'd2, 2'b01);  // crosses top of memory
        wait_done();
        issue_ar(32'h1E, 4'd1, 3'd1, 2'b10);   // narrow WRAP
        wait_done();
        issue_ar(32'h00, 4'd2, 3'd2, 2'b10);   // WRAP with illegal length
        wait_done();
        issue_ar(32'h0A, 4'd1, 3'd2, 2'b10);   // misaligned WRAP
        wait_done();
        issue_ar(32'h00, 4'd0, 3'd3, 2'b01);   // oversize beat
        wait_done();

        RREADY = 1'b0;
        issue_ar(32'h44, 4'd1, 3'd2, 2'b01);
        RREADY    = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = 8'h12;
        mem_wdata = 32'h5555_AAAA;
        @(posedge G_clk); #1;
        mem_we = 1'b0;
        tb_mem[8'h12] = 32'h5555_AAAA;
        wait_done();
        issue_ar(32'h48, 4'd0, 3'd2, 2'b00);
        wait_done();

        issue_ar(32'h80, 4'd7, 3'd2, 2'b01);
        @(posedge G_clk); #1;
        @(posedge G_clk); #1;
        G_reset = 1'b1;
        #1;
        check("midrst_rvalid",  32'(RVALID),  32'd0);
        check("midrst_arready", 32'(ARREADY), 32'd0);
        check("midrst_rlast",   32'(RLAST),   32'd0);
        check("midrst_rdata",   RDATA,        32'd0);
        exp_q.delete();
        @(posedge G_clk); #1;
        G_reset = 1'b0;
        @(posedge G_clk); #1;
        check("arready_after_midrst", 32'(ARREADY), 32'd1);
        issue_ar(32'h100, 4'd1, 3'd2, 2'b01);
        wait_done();

        repeat (3) @(posedge G_clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
